// File: rtl/id_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_fetch_queue_if
//  Brief    : IF->ID queue bus: fetch-side push, decode-side pop, flush
//             control and status. The queue takes the slave modport; the
//             fetch/decode logic (or a testbench) takes the master modport.
//  Revision : 1.0  initial release
// ============================================================================
interface id_fetch_queue_if #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              flush;
   logic              flush_keep;
   logic              stallreq_fetch;
   logic [c_CW-1:0]   count;
   logic              overflow_err;

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready, flush, flush_keep,
      output in_ready, out_valid, out_pc, out_inst, stallreq_fetch, count, overflow_err
   );

   modport master (
      output in_valid, in_pc, in_inst, out_ready, flush, flush_keep,
      input  in_ready, out_valid, out_pc, out_inst, stallreq_fetch, count, overflow_err
   );
endinterface
`default_nettype wire

// File: rtl/id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : id_fetch_queue
//  Brief    : DEPTH-entry circular FIFO of {pc, inst} pairs between IF and ID.
//             Head is read combinationally (no bypass, 1-cycle fill latency),
//             registered fetch-stall request, branch flush with optional
//             delay-slot keep, sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module id_fetch_queue #(
   parameter int DEPTH     = 4,
   parameter int PC_W      = 32,
   parameter int INST_W    = 32,
   parameter int AF_MARGIN = 1
) (
   input  wire                clk,
   input  wire                resetn,
   id_fetch_queue_if.slave    q
);
   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;
   localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF_TH   = c_CW'(DEPTH - AF_MARGIN);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
   localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

   logic [PC_W-1:0]   r_pc_mem   [DEPTH];
   logic [INST_W-1:0] r_inst_mem [DEPTH];

   logic [c_PW-1:0] r_rd_ptr;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;
   logic            r_stall;
   logic            r_ovf;

   logic            w_out_valid;
   logic            w_in_ready;
   logic            w_push;
   logic            w_pop;
   logic            w_e_exists;
   logic [c_PW-1:0] w_e_idx;
   logic            w_wr_en;
   logic [c_PW-1:0] w_rd_next;
   logic [c_PW-1:0] w_wr_next;
   logic [c_CW-1:0] w_cnt_next;

   assign w_out_valid = (r_count != '0);
   // When full, a push is only accepted into the slot the same-cycle pop frees.
   assign w_in_ready  = (r_count != c_FULL) | (w_out_valid & q.out_ready);
   assign w_push      = q.in_valid & w_in_ready;
   assign w_pop       = w_out_valid & q.out_ready;

   // E: oldest entry left after this cycle's pop (the delay slot on flush_keep).
   assign w_e_idx     = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
   assign w_e_exists  = (r_count > (w_pop ? c_CNT_ONE : '0));

   // Next pointer/occupancy; flush overrides normal push/pop bookkeeping.
   always_comb begin
      w_rd_next  = r_rd_ptr;
      w_wr_next  = r_wr_ptr;
      w_cnt_next = r_count;
      w_wr_en    = 1'b0;
      if (q.flush) begin
         if (q.flush_keep && w_e_exists) begin
            w_rd_next  = w_e_idx;
            w_wr_next  = w_e_idx + c_PTR_ONE;
            w_cnt_next = c_CNT_ONE;
         end else if (q.flush_keep && w_push) begin
            w_wr_en    = 1'b1;
            w_rd_next  = r_wr_ptr;
            w_wr_next  = r_wr_ptr + c_PTR_ONE;
            w_cnt_next = c_CNT_ONE;
         end else begin
            w_rd_next  = r_wr_ptr;
            w_cnt_next = '0;
         end
      end else begin
         if (w_push) begin
            w_wr_en   = 1'b1;
            w_wr_next = r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            w_rd_next = r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_count + c_CNT_ONE;
            2'b01:   w_cnt_next = r_count - c_CNT_ONE;
            default: w_cnt_next = r_count;
         endcase
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_pc_mem[r_wr_ptr]   <= q.in_pc;
         r_inst_mem[r_wr_ptr] <= q.in_inst;
      end
   end

   // Control state, stall request and sticky overflow flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_stall  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_next;
         r_wr_ptr <= w_wr_next;
         r_count  <= w_cnt_next;
         r_stall  <= (w_cnt_next >= c_AF_TH);
         // A flush discards the incoming fetch anyway, so it is not an overflow.
         if (q.in_valid && !w_in_ready && !q.flush) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign q.in_ready       = w_in_ready;
   assign q.out_valid      = w_out_valid;
   assign q.out_pc         = w_out_valid ? r_pc_mem[r_rd_ptr]   : '0;
   assign q.out_inst       = w_out_valid ? r_inst_mem[r_rd_ptr] : '0;
   assign q.stallreq_fetch = r_stall;
   assign q.count          = r_count;
   assign q.overflow_err   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_id_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_fetch_queue
//  Brief    : Self-checking bench for id_fetch_queue: stimulus table plus
//             hand sequences, with a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_fetch_queue;
   localparam int DEPTH     = 4;
   localparam int PC_W      = 32;
   localparam int INST_W    = 32;
   localparam int AF_MARGIN = 1;

   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      logic        fl;
      logic        fk;
      int          exp_count;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   entry_t model_q[$];
   logic   m_stall = 1'b0;
   logic   m_ovf   = 1'b0;

   id_fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

   id_fetch_queue #(
      .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .q(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive after negedge, check combinational/registered outputs
   // against the model, advance the model, then move to the next negedge.
   task automatic step(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic fk);
      int     sz;
      logic   m_inr, m_push, m_pop;
      entry_t e;
      bus.in_valid   = iv;
      bus.in_pc      = pc;
      bus.in_inst    = inst_of(pc);
      bus.out_ready  = ordy;
      bus.flush      = fl;
      bus.flush_keep = fk;
      #1;
      sz    = model_q.size();
      m_inr = (sz < DEPTH) || (sz > 0 && ordy);
      chk("in_ready",  64'(bus.in_ready),       64'(m_inr));
      chk("out_valid", 64'(bus.out_valid),      64'(sz != 0));
      chk("count",     64'(bus.count),          64'(sz));
      chk("stallreq",  64'(bus.stallreq_fetch), 64'(m_stall));
      chk("overflow",  64'(bus.overflow_err),   64'(m_ovf));
      if (sz == 0) begin
         chk("idle_pc",   64'(bus.out_pc),   64'd0);
         chk("idle_inst", 64'(bus.out_inst), 64'd0);
      end
      m_push = iv && m_inr;
      m_pop  = (sz != 0) && ordy;
      if (m_pop) begin
         // Scoreboard: popped entry must match the oldest expected one.
         e = model_q.pop_front();
         chk("pop_pc",   64'(bus.out_pc),   64'(e.pc));
         chk("pop_inst", 64'(bus.out_inst), 64'(e.inst));
      end
      if (fl) begin
         if (fk && model_q.size() > 0) begin
            e = model_q[0];
            model_q.delete();
            model_q.push_back(e);
         end else if (fk && m_push) begin
            model_q.delete();
            model_q.push_back('{pc: pc, inst: inst_of(pc)});
         end else begin
            model_q.delete();
         end
      end else begin
         if (m_push) model_q.push_back('{pc: pc, inst: inst_of(pc)});
         if (iv && !m_inr) m_ovf = 1'b1;
      end
      m_stall = (model_q.size() >= DEPTH - AF_MARGIN);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0; bus.flush_keep = 1'b0;
      resetn = 1'b0;
      model_q.delete();
      m_stall = 1'b0;
      m_ovf   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   vec_t vecs[$];

   initial begin
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
      bus.out_ready = 1'b0; bus.flush = 1'b0; bus.flush_keep = 1'b0;

      // Stimulus table: fill, full-with-pop, overflow, drain.
      vecs.push_back('{1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 2});
      vecs.push_back('{1'b1, 32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 3});
      vecs.push_back('{1'b1, 32'hBFC0_000C, 1'b0, 1'b0, 1'b0, 4});
      vecs.push_back('{1'b1, 32'hBFC0_0010, 1'b1, 1'b0, 1'b0, 4});
      vecs.push_back('{1'b1, 32'hBFC0_0014, 1'b0, 1'b0, 1'b0, 4});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 2});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 0});

      do_reset();
      // Reset state, sampled while reset was held then released.
      chk("rst_count",    64'(bus.count),          64'd0);
      chk("rst_valid",    64'(bus.out_valid),      64'd0);
      chk("rst_pc",       64'(bus.out_pc),         64'd0);
      chk("rst_stall",    64'(bus.stallreq_fetch), 64'd0);
      chk("rst_overflow", 64'(bus.overflow_err),   64'd0);

      foreach (vecs[i]) begin
         step(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl, vecs[i].fk);
         #1;
         chk($sformatf("tbl_count[%0d]", i), 64'(bus.count), 64'(vecs[i].exp_count));
         if (i == 3) begin
            chk("full_head_pc", 64'(bus.out_pc), 64'hBFC0_0000);
            chk("full_stall",   64'(bus.stallreq_fetch), 64'd1);
            chk("full_in_ready", 64'(bus.in_ready), 64'd0);
         end
         if (i == 4) begin
            chk("wr_pop_head", 64'(bus.out_pc), 64'hBFC0_0004);
            chk("wr_pop_ovf",  64'(bus.overflow_err), 64'd0);
         end
         if (i == 5) begin
            chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);
            chk("ovf_head",   64'(bus.out_pc), 64'hBFC0_0004);
         end
      end

      // Flush keeping the delay slot: count=3, pop + keep -> 0x104 remains.
      do_reset();
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0,   1'b1, 1'b1, 1'b1);
      #1;
      chk("keep_count", 64'(bus.count),    64'd1);
      chk("keep_pc",    64'(bus.out_pc),   64'h104);
      chk("keep_inst",  64'(bus.out_inst), 64'(inst_of(32'h104)));

      // Flush without keep while pushing into an empty queue: push dropped.
      step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
      #1;
      chk("fl_drop_count", 64'(bus.count),        64'd0);
      chk("fl_drop_valid", 64'(bus.out_valid),    64'd0);
      chk("fl_drop_inst",  64'(bus.out_inst),     64'd0);
      chk("fl_drop_ovf",   64'(bus.overflow_err), 64'd0);

      // Flush keep with nothing left after pop: the same-cycle push survives.
      step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h304, 1'b1, 1'b1, 1'b1);
      #1;
      chk("keep_push_count", 64'(bus.count),  64'd1);
      chk("keep_push_pc",    64'(bus.out_pc), 64'h304);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Streaming with out_ready toggling: pointers wrap, order preserved.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 32'h1000 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0);
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("stream_drained", 64'(bus.count), 64'd0);

      // Mid-operation async reset drops everything at once.
      step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_count", 64'(bus.count),     64'd0);
      chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
      model_q.delete();
      m_stall = 1'b0;
      m_ovf   = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
      #1;
      chk("post_rst_pc", 64'(bus.out_pc), 64'h500);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
